// File: rtl/tpu_pkg.sv
// Shared constants and state type for the systolic matrix unit.
package tpu_pkg;
  localparam int TPU_N      = 8;
  localparam int TPU_DATA_W = 16;

  typedef enum logic {COLLECT, FULL} gather_state_t;
endpackage

// File: rtl/output_gather_if.sv
// Lane-beat inputs and matrix valid/ready output of the result collector.
// The slave modport is the collector side; master is the array/writeback side.
interface output_gather_if #(
  parameter int N      = 8,
  parameter int DATA_W = 16
);
  logic [N-1:0]             lane_valid;
  logic [N-1:0][DATA_W-1:0] lane_data;
  logic                     in_ready;
  logic                     mat_valid;
  logic                     mat_ready;
  logic [N*N*DATA_W-1:0]    c_mat;

  modport slave  (input  lane_valid, lane_data, mat_ready,
                  output in_ready, mat_valid, c_mat);
  modport master (output lane_valid, lane_data, mat_ready,
                  input  in_ready, mat_valid, c_mat);
endinterface

// File: rtl/output_gather_lane.sv
// gather_lane: one array column. Holds the row counter and the N result
// elements of that column. With OUTPUT_GATHER_RELU_EN defined, negative
// (signed) elements are stored as zero.
module gather_lane
  import tpu_pkg::*;
#(
  parameter int N      = TPU_N,
  parameter int DATA_W = TPU_DATA_W,
  parameter int CW     = $clog2(N + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     hs,
  input  logic                     beat,
  input  logic                     in_ready,
  input  logic [DATA_W-1:0]        data,
  output logic                     lane_full,
  output logic                     overrun,
  output logic [N-1:0][DATA_W-1:0] elems
);
  logic [CW-1:0]     cnt;
  logic              take;
  logic              acc;
  logic [DATA_W-1:0] store;

  assign take    = beat && in_ready && !clear;
  assign acc     = take && (cnt < CW'(N));
  assign overrun = take && (cnt == CW'(N));
  // full now, or becomes full at this edge
  assign lane_full = (cnt == CW'(N)) || (acc && (cnt == CW'(N - 1)));

`ifdef OUTPUT_GATHER_RELU_EN
  assign store = data[DATA_W-1] ? '0 : data;
`else
  assign store = data;
`endif

  // row counter: cleared on abort or matrix handoff, else counts accepted beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           cnt <= '0;
    else if (clear || hs) cnt <= '0;
    else if (acc)        cnt <= cnt + CW'(1);
  end

  // element capture at the current row; contents persist across matrices
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elems <= '0;
    end else begin
      for (int r = 0; r < N; r++)
        if (acc && (cnt == CW'(r))) elems[r] <= store;
    end
  end
endmodule

// File: rtl/output_gather.sv
// output_gather: assembles skewed per-column result streams of the systolic
// array into a full NxN matrix and hands it to writeback on valid/ready.
// Optional build macro: OUTPUT_GATHER_RELU_EN (ReLU on stored elements).
module output_gather
  import tpu_pkg::*;
#(
  parameter int N      = TPU_N,
  parameter int DATA_W = TPU_DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  output_gather_if.slave  bus,
  output logic            err
);
  gather_state_t                    state, state_nxt;
  logic                             in_rdy;
  logic                             hs;
  logic [N-1:0]                     lane_full;
  logic [N-1:0]                     overrun;
  logic [N-1:0][N-1:0][DATA_W-1:0]  lane_elems;

  assign in_rdy        = (state == COLLECT);
  assign hs            = (state == FULL) && bus.mat_ready;
  assign bus.in_ready  = in_rdy;
  assign bus.mat_valid = (state == FULL);

  gather_lane #(.N(N), .DATA_W(DATA_W)) u_lane [N-1:0] (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .hs        (hs),
    .beat      (bus.lane_valid),
    .in_ready  (in_rdy),
    .data      (bus.lane_data),
    .lane_full (lane_full),
    .overrun   (overrun),
    .elems     (lane_elems)
  );

  // element (r,c) of C comes from row r of lane c
  for (genvar c = 0; c < N; c++) begin : g_col
    for (genvar r = 0; r < N; r++) begin : g_row
      assign bus.c_mat[(r*N+c)*DATA_W +: DATA_W] = lane_elems[c][r];
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_nxt;
  end

  // next state: clear wins over everything, including the handshake
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (&lane_full)    state_nxt = FULL;
        FULL:    if (bus.mat_ready) state_nxt = COLLECT;
        default:                    state_nxt = COLLECT;
      endcase
    end
  end

  // sticky protocol error: overrun, or beats offered while not ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else if (!clear && ((|overrun) || ((|bus.lane_valid) && !in_rdy)))
      err <= 1'b1;
  end
endmodule

// File: tb/tb_output_gather.sv
// Self-checking bench for output_gather: scoreboard of expected matrices.
module tb_output_gather;
  localparam int N = 8;
  localparam int W = 16;
  localparam int MW = N * N * W;

  logic clk, reset, clear, err;
  output_gather_if #(.N(N), .DATA_W(W)) bus ();

  output_gather #(.N(N), .DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [MW-1:0] sb[$];
  logic [MW-1:0] last_exp = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] elem(input logic [MW-1:0] m, input int r, input int c);
    return m[(r*N+c)*W +: W];
  endfunction

  function automatic logic [W-1:0] relu(input logic [W-1:0] v);
`ifdef OUTPUT_GATHER_RELU_EN
    return v[W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [W-1:0] val(input int mode, input int r, input int j);
    case (mode)
      0: return W'(16 * r + j);
      1: return W'(16'h0100 + r);
      default: begin
        if (r == 0 && j == 0) return 16'hFFF0;
        if (r == 0 && j == 1) return 16'h7FFF;
        if (r == 1 && j == 0) return 16'h8000;
        return W'(r * j + 16'h40);
      end
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // perfectly diagonal fill: lane j beats at cycles j..j+7
  task automatic fill(input int mode);
    logic [MW-1:0] e;
    e = '0;
    for (int t = 0; t < 2 * N - 1; t++) begin
      for (int j = 0; j < N; j++) begin
        int r;
        r = t - j;
        if (r >= 0 && r < N) begin
          bus.lane_valid[j] = 1'b1;
          bus.lane_data[j]  = val(mode, r, j);
          e[(r*N+j)*W +: W] = relu(val(mode, r, j));
        end else begin
          bus.lane_valid[j] = 1'b0;
          bus.lane_data[j]  = W'($urandom);
        end
      end
      if (t == 2 * N - 2) check($sformatf("m%0d_valid_before_last", mode), bus.mat_valid, 1'b0);
      step();
    end
    bus.lane_valid = '0;
    sb.push_back(e);
    check($sformatf("m%0d_valid_at_last", mode), bus.mat_valid, 1'b1);
    check($sformatf("m%0d_inrdy_at_last", mode), bus.in_ready, 1'b0);
  endtask

  // bounded wait for a matrix, then compare against the scoreboard head
  task automatic cmp_mat(input string tag);
    logic [MW-1:0] e;
    for (int i = 0; i < 4 && !bus.mat_valid; i++) step();
    if (!bus.mat_valid) begin
      check({tag, "_timeout"}, 1'b0, 1'b1);
    end else if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b0, 1'b1);
    end else begin
      e = sb.pop_front();
      last_exp = e;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          check($sformatf("%s[%0d][%0d]", tag, r, c), elem(bus.c_mat, r, c), elem(e, r, c));
    end
  endtask

  task automatic handshake(input string tag);
    bus.mat_ready = 1'b1;
    step();
    bus.mat_ready = 1'b0;
    check({tag, "_hs_valid"}, bus.mat_valid, 1'b0);
    check({tag, "_hs_inrdy"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    clear = 1'b0;
    bus.lane_valid = '0;
    bus.lane_data  = '0;
    bus.mat_ready  = 1'b0;
    #23 reset = 1'b0;
    check("rst_inrdy", bus.in_ready, 1'b1);
    check("rst_valid", bus.mat_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cmat", bus.c_mat == '0, 1'b1);
    step();

    // diagonal fill with 16*r+j
    fill(0);
    cmp_mat("diag");
    check("diag_c35", elem(bus.c_mat, 3, 5), 16'h0035);

    // backpressure: matrix held stable while writeback stalls
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("bp_stable_%0d", i), bus.c_mat === last_exp, 1'b1);
      check($sformatf("bp_inrdy_%0d", i), bus.in_ready, 1'b0);
      check($sformatf("bp_valid_%0d", i), bus.mat_valid, 1'b1);
    end
    handshake("bp");
    check("bp_retained", bus.c_mat === last_exp, 1'b1);
    check("bp_err", err, 1'b0);

    // overrun: 9 beats on lane 2 only
    for (int r = 0; r < N + 1; r++) begin
      bus.lane_valid = 8'h04;
      bus.lane_data[2] = W'(16'h0200 + r);
      step();
    end
    bus.lane_valid = '0;
    step();
    check("ovr_err", err, 1'b1);
    check("ovr_e72", elem(bus.c_mat, 7, 2), 16'h0207);
    check("ovr_valid", bus.mat_valid, 1'b0);

    // clear after 4 beats per lane, then a full fresh fill
    for (int r = 0; r < 4; r++) begin
      bus.lane_valid = '1;
      for (int j = 0; j < N; j++) bus.lane_data[j] = W'(16'h0300 + r);
      step();
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    bus.lane_valid = '0;
    check("clr_err_kept", err, 1'b1);
    check("clr_valid", bus.mat_valid, 1'b0);
    check("clr_inrdy", bus.in_ready, 1'b1);
    fill(1);
    cmp_mat("clr");
    check("clr_c00", elem(bus.c_mat, 0, 0), 16'h0100);
    handshake("clr");

    // ReLU behaviour on negative / max-positive elements
    fill(2);
    cmp_mat("relu");
`ifdef OUTPUT_GATHER_RELU_EN
    check("relu_c00", elem(bus.c_mat, 0, 0), 16'h0000);
    check("relu_c10", elem(bus.c_mat, 1, 0), 16'h0000);
`else
    check("relu_c00", elem(bus.c_mat, 0, 0), 16'hFFF0);
    check("relu_c10", elem(bus.c_mat, 1, 0), 16'h8000);
`endif
    check("relu_c01", elem(bus.c_mat, 0, 1), 16'h7FFF);
    handshake("relu");

    // asynchronous reset in the middle of a fill
    for (int r = 0; r < 3; r++) begin
      bus.lane_valid = '1;
      for (int j = 0; j < N; j++) bus.lane_data[j] = W'(16'h0500 + r);
      step();
    end
    #2 reset = 1'b1;
    #1;
    check("arst_inrdy", bus.in_ready, 1'b1);
    check("arst_valid", bus.mat_valid, 1'b0);
    check("arst_err", err, 1'b0);
    check("arst_cmat", bus.c_mat == '0, 1'b1);
    bus.lane_valid = '0;
    #3 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.mat_valid) seen = 1'b1;
    end
    check("arst_no_valid", seen, 1'b0);

    // clean fill after reset: no stale partial rows
    fill(0);
    cmp_mat("post");
    handshake("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
